// File: rtl/pipelined_carry_adder_nb_pkg.sv
// Shared ALU definitions: default adder geometry, the operation encoding
// and the effective carry-in helper used by the pipelined adder.
package alu_pkg;

  localparam int ALU_DEFAULT_N      = 32;
  localparam int ALU_DEFAULT_STAGES = 4;

  // Operation encoding as {inv_b, carry}.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,  // a + b
    OP_ADDC = 2'b01,  // a + b + 1
    OP_SUB  = 2'b10,  // a - b
    OP_SUBB = 2'b11   // a - b - 1
  } op_e;

  // Subtraction is a + ~b + 1, so the user carry is inverted along with B:
  // carry=0 then gives a plain a-b and carry=1 gives a borrow (a-b-1).
  function automatic logic eff_carry_in(input logic carry, input logic inv_b);
    return inv_b ? ~carry : carry;
  endfunction

endpackage

// File: rtl/pipelined_carry_adder_nb_if.sv
// Operand/result handshake bundle for the pipelined adder.
// Flag outputs exist only when PIPELINED_ADDER_FLAGS_EN is defined.
interface pipelined_carry_adder_nb_if #(
  parameter int N = alu_pkg::ALU_DEFAULT_N
);
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] opa_i;
  logic [N-1:0] opb_i;
  logic         carry_i;
  logic         inv_b_i;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] res_o;
  logic         carry_o;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic         overflow_o;
  logic         zero_o;
`endif

  // Producer/consumer side: drives operations in and accepts results.
  modport master (
    output valid_i, opa_i, opb_i, carry_i, inv_b_i, ready_i,
`ifdef PIPELINED_ADDER_FLAGS_EN
    input  overflow_o, zero_o,
`endif
    input  ready_o, valid_o, res_o, carry_o
  );

  // Adder side.
  modport slave (
    input  valid_i, opa_i, opb_i, carry_i, inv_b_i, ready_i,
`ifdef PIPELINED_ADDER_FLAGS_EN
    output overflow_o, zero_o,
`endif
    output ready_o, valid_o, res_o, carry_o
  );

endinterface

// File: rtl/pipelined_carry_adder_nb_segment.sv
// Carry-chain building blocks: a 1-bit full adder cell and a W-bit ripple
// segment chained from those cells. One segment is resolved per pipe stage.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  // Each bit keeps its own carry wires so the chain is a plain ripple of cells.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic w_ci;
    logic w_co;
    if (i == 0) begin : g_lsb
      assign w_ci = ci;
    end else begin : g_chain
      assign w_ci = g_bit[i-1].w_co;
    end
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_ci),
      .s  (s[i]),
      .co (w_co)
    );
  end

  assign co = g_bit[W-1].w_co;
endmodule

// File: rtl/pipelined_carry_adder_nb.sv
// Pipelined N-bit adder/subtractor with valid/ready on both sides.
// The carry chain is cut into STAGES segments of SEG bits; stage k finishes
// bits [(k+1)*SEG-1:k*SEG] and passes the remaining operand bits onward.
// Bubbles collapse: a slot loads whenever it is empty or its contents move on.
// Optional signed-overflow/zero flags: define PIPELINED_ADDER_FLAGS_EN.
module pipelined_carry_adder_nb
  import alu_pkg::*;
#(
  parameter int N      = ALU_DEFAULT_N,
  parameter int STAGES = ALU_DEFAULT_STAGES
) (
  input logic                      clk_i,
  input logic                      rst_i,
  pipelined_carry_adder_nb_if.slave bus
);

  localparam int SEG = N / STAGES;

  // Effective B operand and carry-in for the requested operation.
  logic [N-1:0] w_b_eff;
  logic         w_c0;
  assign w_b_eff = bus.inv_b_i ? ~bus.opb_i : bus.opb_i;
  assign w_c0    = eff_carry_in(bus.carry_i, bus.inv_b_i);

  // Slot state. r_a/r_b hold the not-yet-added operand bits shifted down so
  // the next segment always sits at bit 0; r_res holds the finished low bits.
  logic [STAGES-1:0] r_v;
  logic [N-1:0]      r_res [STAGES];
  logic [N-1:0]      r_a   [STAGES];
  logic [N-1:0]      r_b   [STAGES];
  logic              r_c   [STAGES];

  // Per-stage segment inputs/outputs and next-state data.
  logic [SEG-1:0]    w_a_seg   [STAGES];
  logic [SEG-1:0]    w_b_seg   [STAGES];
  logic              w_ci      [STAGES];
  logic [SEG-1:0]    w_s       [STAGES];
  logic              w_co      [STAGES];
  logic [N-1:0]      w_a_nxt   [STAGES];
  logic [N-1:0]      w_b_nxt   [STAGES];
  logic [N-1:0]      w_res_nxt [STAGES];
  logic [STAGES-1:0] w_v_in;

  // Handshake: w_load[k] = slot k may take new contents this cycle,
  // w_adv[k] = something moves into slot k (w_adv[STAGES] = result taken).
  logic [STAGES:0]   w_adv;
  logic [STAGES-1:0] w_load;

  // Ready propagates backwards from the consumer, one slot at a time.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_adv  = '0;
    w_load = '0;
    w_adv[STAGES] = bus.ready_i;
    for (int k = STAGES - 1; k >= 1; k--) begin
      w_load[k] = !r_v[k] || w_adv[k+1];
      w_adv[k]  = r_v[k-1] && w_load[k];
    end
    w_load[0] = !r_v[0] || w_adv[1];
    w_adv[0]  = bus.valid_i && w_load[0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_seg[k]   = bus.opa_i[SEG-1:0];
      assign w_b_seg[k]   = w_b_eff[SEG-1:0];
      assign w_ci[k]      = w_c0;
      assign w_a_nxt[k]   = bus.opa_i >> SEG;
      assign w_b_nxt[k]   = w_b_eff >> SEG;
      assign w_res_nxt[k] = N'(w_s[k]);
      assign w_v_in[k]    = bus.valid_i;
    end else begin : g_next
      assign w_a_seg[k]   = r_a[k-1][SEG-1:0];
      assign w_b_seg[k]   = r_b[k-1][SEG-1:0];
      assign w_ci[k]      = r_c[k-1];
      assign w_a_nxt[k]   = r_a[k-1] >> SEG;
      assign w_b_nxt[k]   = r_b[k-1] >> SEG;
      assign w_res_nxt[k] = r_res[k-1] | (N'(w_s[k]) << (k * SEG));
      assign w_v_in[k]    = r_v[k-1];
    end

    adder_segment #(.W(SEG)) u_seg (
      .a  (w_a_seg[k]),
      .b  (w_b_seg[k]),
      .ci (w_ci[k]),
      .s  (w_s[k]),
      .co (w_co[k])
    );
  end

  // Slot registers: valid follows every load, data only loads with a valid op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: data registers are reset too, so res_o/carry_o read 0 after
      // reset instead of a stale sum from a dropped operation.
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_res[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking so each slot samples its predecessor's pre-edge value.
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k] <= w_v_in[k];
          if (w_v_in[k]) begin
            r_res[k] <= w_res_nxt[k];
            r_a[k]   <= w_a_nxt[k];
            r_b[k]   <= w_b_nxt[k];
            r_c[k]   <= w_co[k];
          end
        end
      end
    end
  end

  assign bus.ready_o = w_load[0];
  assign bus.valid_o = r_v[STAGES-1];
  assign bus.res_o   = r_res[STAGES-1];
  assign bus.carry_o = r_c[STAGES-1];

`ifdef PIPELINED_ADDER_FLAGS_EN
  // Operand sign bits ride along with each slot for the overflow decision.
  logic r_amsb [STAGES];
  logic r_bmsb [STAGES];
  logic w_amsb_in [STAGES];
  logic w_bmsb_in [STAGES];
  logic r_ovf;
  logic r_zero;
  logic w_ovf_nxt;

  for (genvar k = 0; k < STAGES; k++) begin : g_msb
    if (k == 0) begin : g_first
      assign w_amsb_in[k] = bus.opa_i[N-1];
      assign w_bmsb_in[k] = w_b_eff[N-1];
    end else begin : g_next
      assign w_amsb_in[k] = r_amsb[k-1];
      assign w_bmsb_in[k] = r_bmsb[k-1];
    end
  end

  assign w_ovf_nxt = (w_amsb_in[STAGES-1] == w_bmsb_in[STAGES-1]) &&
                     (w_res_nxt[STAGES-1][N-1] != w_amsb_in[STAGES-1]);

  // Sign bits move with their slot; flags load together with the final slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        r_amsb[k] <= 1'b0;
        r_bmsb[k] <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k] && w_v_in[k]) begin
          r_amsb[k] <= w_amsb_in[k];
          r_bmsb[k] <= w_bmsb_in[k];
        end
      end
      if (w_load[STAGES-1] && w_v_in[STAGES-1]) begin
        r_ovf  <= w_ovf_nxt;
        r_zero <= (w_res_nxt[STAGES-1] == '0);
      end
    end
  end

  assign bus.overflow_o = r_ovf;
  assign bus.zero_o     = r_zero;
`endif

endmodule
